// File: rtl/tc77_pkg.sv
// Shared definitions for the TC77 sensor emulator.
package tc77_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT_OUT,
    ST_CFG_IN,
    ST_COMMIT
  } tc77_state_e;

  localparam logic [15:0] CFG_SHUTDOWN   = 16'hFFFF;
  localparam logic [15:0] CFG_CONTINUOUS = 16'h0000;
  localparam int          PAD_BITS       = 2;
  localparam int          CFG_BITS       = 16;

  // Serial word: temperature field, ready bit, then the undriven pad bits.
  function automatic int word_width(input int data_width);
    return data_width + 1 + PAD_BITS;
  endfunction

endpackage

// File: rtl/tc77_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pad input, with single-cycle
// rise/fall pulses derived from the synchronised copy.
module tc77_sync_edge #(
  parameter int   SYNC_STAGES = 2,
  parameter logic RESET_VAL   = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] chain_q;
  logic [SYNC_STAGES-1:0] chain_d;
  logic                   prev_q;
  logic                   prev_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_chain
      if (gi == 0) begin : g_first
        assign chain_d[gi] = async_in;
      end else begin : g_next
        assign chain_d[gi] = chain_q[gi-1];
      end
    end
  endgenerate

  assign sync_out = chain_q[SYNC_STAGES-1];
  assign prev_d   = sync_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= {SYNC_STAGES{RESET_VAL}};
      prev_q  <= RESET_VAL;
    end else begin
      chain_q <= chain_d;
      prev_q  <= prev_d;
    end
  end

  assign rise = sync_out & ~prev_q;
  assign fall = ~sync_out & prev_q;

endmodule

// File: rtl/tc77_emulator.sv
// TC77-style SPI temperature-sensor emulator: serves a host-loaded table of
// readings over 3-wire SPI and models conversion-ready, config write and shutdown.
module tc77_emulator
  import tc77_pkg::*;
#(
  parameter int DATA_WIDTH  = 13,
  parameter int DEPTH       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int CONV_CYCLES = 1024,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic                  MCLK,
  input  logic                  nRESET,
  input  logic                  nCS,
  input  logic                  SCK,
  input  logic                  SIO_IN,
  output logic                  SIO_OUT,
  output logic                  SIO_OE,
  input  logic                  TBL_WE,
  input  logic [AW-1:0]         TBL_ADDR,
  input  logic [DATA_WIDTH-1:0] TBL_DATA,
  input  logic [AW-1:0]         TBL_LAST,
  output logic [AW-1:0]         RD_PTR,
  output logic                  SHUTDOWN,
  output logic [15:0]           CFG_WORD,
  output logic                  BUSY
);

  localparam int WW        = word_width(DATA_WIDTH);
  localparam int SEND_BITS = DATA_WIDTH + 1;
  localparam int BCW       = $clog2(SEND_BITS + 1);
  localparam int TW        = $clog2(CONV_CYCLES + 1);

  logic ncs_sync, ncs_rise, ncs_fall;
  logic sck_sync_unused, sck_rise, sck_fall;
  logic sio_sync, sio_rise_unused, sio_fall_unused;

  tc77_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ncs (
    .clk(MCLK), .rst_n(nRESET), .async_in(nCS),
    .sync_out(ncs_sync), .rise(ncs_rise), .fall(ncs_fall)
  );

  tc77_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sck (
    .clk(MCLK), .rst_n(nRESET), .async_in(SCK),
    .sync_out(sck_sync_unused), .rise(sck_rise), .fall(sck_fall)
  );

  tc77_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sio (
    .clk(MCLK), .rst_n(nRESET), .async_in(SIO_IN),
    .sync_out(sio_sync), .rise(sio_rise_unused), .fall(sio_fall_unused)
  );

  // Reading table.  No reset: contents survive nRESET like a real RAM.
  logic [DATA_WIDTH-1:0] tbl_mem [DEPTH];
  logic [DATA_WIDTH-1:0] tbl_rd;

  always_ff @(posedge MCLK) begin
    if (TBL_WE) begin
      tbl_mem[TBL_ADDR] <= TBL_DATA;
    end
  end

  tc77_state_e     state_q, state_d;
  logic [WW-1:0]   shift_q, shift_d;
  logic [BCW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]     cfg_q, cfg_d;
  logic [4:0]      cfg_cnt_q, cfg_cnt_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic            shutdown_q, shutdown_d;
  logic [15:0]     cfg_word_q, cfg_word_d;
  logic [TW-1:0]   timer_q, timer_d;
  logic            sio_out_q, sio_out_d;
  logic            sio_oe_q, sio_oe_d;
  logic            ready;

  assign tbl_rd = tbl_mem[rd_ptr_q];
  assign ready  = ~shutdown_q & (timer_q == '0);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    cfg_d      = cfg_q;
    cfg_cnt_d  = cfg_cnt_q;
    rd_ptr_d   = rd_ptr_q;
    shutdown_d = shutdown_q;
    cfg_word_d = cfg_word_q;
    timer_d    = timer_q;

    case (state_q)
      ST_IDLE: begin
        if (ncs_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        shift_d   = {tbl_rd, ready, {PAD_BITS{1'b0}}};
        bit_cnt_d = '0;
        cfg_d     = '0;
        cfg_cnt_d = '0;
        state_d   = ST_SHIFT_OUT;
      end
      ST_SHIFT_OUT: begin
        if (sck_fall) begin
          shift_d   = shift_q << 1;
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == BCW'(SEND_BITS - 1)) state_d = ST_CFG_IN;
        end
      end
      ST_CFG_IN: begin
        if (sck_rise && (cfg_cnt_q != 5'(CFG_BITS))) begin
          cfg_d     = {cfg_q[14:0], sio_sync};
          cfg_cnt_d = cfg_cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        if (bit_cnt_q == BCW'(SEND_BITS)) begin
          rd_ptr_d = (rd_ptr_q >= TBL_LAST) ? '0 : rd_ptr_q + 1'b1;
        end
        if (cfg_cnt_q == 5'(CFG_BITS)) begin
          cfg_word_d = cfg_q;
          if (cfg_q == CFG_SHUTDOWN)        shutdown_d = 1'b1;
          else if (cfg_q == CFG_CONTINUOUS) shutdown_d = 1'b0;
        end
        // Clear the counts so a stray nCS rise in IDLE cannot re-commit them.
        bit_cnt_d = '0;
        cfg_cnt_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    if (ncs_rise && (state_q != ST_COMMIT)) state_d = ST_COMMIT;

    if (shutdown_q) begin
      if (!shutdown_d) timer_d = TW'(CONV_CYCLES);
    end else if (!shutdown_d && (timer_q != '0)) begin
      timer_d = timer_q - 1'b1;
    end

    // Pad bits and config phase are never driven.
    sio_oe_d  = (state_d == ST_SHIFT_OUT);
    sio_out_d = sio_oe_d & shift_d[WW-1];
  end

  always_ff @(posedge MCLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      cfg_q      <= '0;
      cfg_cnt_q  <= '0;
      rd_ptr_q   <= '0;
      shutdown_q <= 1'b0;
      cfg_word_q <= '0;
      timer_q    <= TW'(CONV_CYCLES);
      sio_out_q  <= 1'b0;
      sio_oe_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      cfg_q      <= cfg_d;
      cfg_cnt_q  <= cfg_cnt_d;
      rd_ptr_q   <= rd_ptr_d;
      shutdown_q <= shutdown_d;
      cfg_word_q <= cfg_word_d;
      timer_q    <= timer_d;
      sio_out_q  <= sio_out_d;
      sio_oe_q   <= sio_oe_d;
    end
  end

  assign SIO_OUT  = sio_out_q;
  assign SIO_OE   = sio_oe_q;
  assign RD_PTR   = rd_ptr_q;
  assign SHUTDOWN = shutdown_q;
  assign CFG_WORD = cfg_word_q;
  assign BUSY     = ~ncs_sync;

endmodule
